// File: rtl/matmul_pkg.sv
// Shared constants and readout FSM state type for the matrix-multiply result path.
package matmul_pkg;
  localparam int MAT_DIM  = 8;
  localparam int C_ELEMS  = 64;
  localparam int C_DATA_W = 19;
  localparam int C_ADDR_W = 6;

  typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_DRAIN, RD_DONE} readout_state_t;
endpackage

// File: rtl/readout_skid_buf.sv
// Two-entry FIFO holding {index,last,data} beats between the result RAM and the output port.
module readout_skid_buf #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [1:0][W-1:0] mem;
  logic              wr_ptr, rd_ptr;

  // When full, wr_ptr equals rd_ptr: a push+pop overwrites the slot being popped,
  // which then becomes the tail once rd_ptr advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout = mem[rd_ptr];
endmodule

// File: rtl/result_readout.sv
// Streams the C result RAM out over valid/ready in address order after a start pulse.
// Optional running checksum port enabled by RESULT_READOUT_CHECKSUM_EN.
module result_readout
  import matmul_pkg::*;
#(
  parameter int N_ELEMS = C_ELEMS,
  parameter int DATA_W  = C_DATA_W,
  parameter int ADDR_W  = C_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last
`ifdef RESULT_READOUT_CHECKSUM_EN
  ,output logic [DATA_W+ADDR_W-1:0] out_checksum
`endif
);
  localparam int EW = ADDR_W + 1 + DATA_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_ELEMS - 1);

  readout_state_t    state;
  logic [ADDR_W-1:0] rd_ptr, fl_idx;
  logic              fl_vld, issue, pop;
  logic [1:0]        count;
  logic [EW-1:0]     din, dout;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign {out_index, out_last, out_data} = dout;

  // Credit counts occupancy net of this cycle's pop plus the read in flight, so a
  // steady ready stream keeps one read per cycle without ever overfilling the buffer.
  assign issue = (state == RD_FETCH) &&
                 (({1'b0, count} + {2'b0, fl_vld} - {2'b0, pop}) < 3'd2);

  assign ram_rd_en = issue;
  assign ram_addr  = rd_ptr;
  assign din       = {fl_idx, (fl_idx == LAST_ADDR), ram_rdata};

  readout_skid_buf #(.W(EW)) u_skid (
    .clk   (clk),
    .reset (reset),
    .push  (fl_vld),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RD_IDLE;
      rd_ptr <= '0;
      fl_vld <= 1'b0;
      fl_idx <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      fl_vld <= issue;
      if (issue) fl_idx <= rd_ptr;
      done <= 1'b0;
      case (state)
        RD_IDLE: if (start) begin
          state  <= RD_FETCH;
          rd_ptr <= '0;
          busy   <= 1'b1;
        end
        RD_FETCH: if (issue) begin
          // Address parks on the last element so it never wraps within a pass.
          if (rd_ptr == LAST_ADDR) state <= RD_DRAIN;
          else rd_ptr <= rd_ptr + ADDR_W'(1);
        end
        RD_DRAIN: if (pop && out_last) begin
          state <= RD_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= RD_IDLE;
      endcase
    end
  end

`ifdef RESULT_READOUT_CHECKSUM_EN
  localparam int CW = DATA_W + ADDR_W;
  logic [CW-1:0] csum;

  always_ff @(posedge clk) begin
    if (reset) csum <= '0;
    else if (state == RD_IDLE && start) csum <= '0;
    else if (pop) csum <= csum + CW'($signed(out_data));
  end

  assign out_checksum = csum;
`endif
endmodule

// File: tb/tb_result_readout.sv
// Directed bench for result_readout: streaming, stalls, sign extremes, restart, mid-pass reset.
module tb_result_readout;
  localparam int N = 64, DW = 19, AW = 6, CW = 25;

  logic          clk = 1'b0;
  logic          reset, start, out_ready;
  logic          busy, done, ram_rd_en, out_valid, out_last;
  logic [AW-1:0] ram_addr, out_index;
  logic [DW-1:0] ram_rdata, out_data;
`ifdef RESULT_READOUT_CHECKSUM_EN
  logic [CW-1:0] out_checksum;
`endif

  result_readout dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .ram_rd_en (ram_rd_en),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last)
`ifdef RESULT_READOUT_CHECKSUM_EN
    ,.out_checksum (out_checksum)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [N];
  always_ff @(posedge clk) if (ram_rd_en) ram_rdata <= mem[ram_addr];

  int vecs = 0, errs = 0;
  int exp_idx, issued, first_x, last_x, stalls;
  logic last_prev, stall_prev, done_seen, restarted, xfer;
  logic [DW-1:0] hold_d;
  logic [AW-1:0] hold_i;
  logic hold_l;
  logic [CW-1:0] sum;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy_for(input int mode, input int t);
    case (mode)
      1:       return (t < 40) ? (t % 2 == 0) : (t >= 50);
      6:       return (t >= 10);
      default: return 1'b1;
    endcase
  endfunction

  // One readout pass. t=0 is the cycle right after the edge that samples start.
  task automatic run_pass(input int mode, input int abort_at, input int restart_beat);
    exp_idx = 0; issued = 0; first_x = -1; last_x = -1; stalls = 0;
    last_prev = 0; stall_prev = 0; done_seen = 0; restarted = 0; sum = '0;
    @(negedge clk); start = 1'b1; out_ready = rdy_for(mode, 0);
    for (int t = 0; t < 400 && !done_seen; t++) begin
      @(negedge clk);
      out_ready = (abort_at >= 0 && exp_idx >= abort_at) ? 1'b0 : rdy_for(mode, t);
      start = (restart_beat >= 0 && exp_idx == restart_beat && !restarted);
      if (start) restarted = 1'b1;
      #1;
      chk("done_timing", 64'(done), 64'(last_prev));
      if (t == 0) begin
        chk("first_issue", 64'({busy, ram_rd_en, ram_addr, out_valid}), 64'({1'b1, 1'b1, 6'd0, 1'b0}));
`ifdef RESULT_READOUT_CHECKSUM_EN
        chk("csum_clear", 64'(out_checksum), 64'd0);
`endif
      end
      if (t == 1) chk("valid_latency", 64'(out_valid), 64'd0);
      if (stall_prev)
        chk("stall_hold", 64'({out_valid, out_index, out_last, out_data}), 64'({1'b1, hold_i, hold_l, hold_d}));
      if (ram_rd_en) begin
        chk("rd_addr", 64'(ram_addr), 64'(issued));
        issued++;
      end
      xfer = out_valid && out_ready;
      if (xfer) begin
        chk("beat", 64'({out_index, out_last, out_data}),
            64'({6'(exp_idx), (exp_idx == N - 1), mem[exp_idx]}));
        if (first_x < 0) first_x = t;
        last_x = t;
        sum = sum + {{(CW-DW){out_data[DW-1]}}, out_data};
        exp_idx++;
      end
      chk("outstanding", 64'((issued - exp_idx) <= 2), 64'd1);
      if (mode == 6 && t == 9) chk("stalled_issues", 64'(issued), 64'd2);
      if (done) begin
        done_seen = 1'b1;
        chk("busy_at_done", 64'(busy), 64'd0);
`ifdef RESULT_READOUT_CHECKSUM_EN
        chk("csum", 64'(out_checksum), 64'(sum));
`endif
      end
      last_prev = xfer && out_last;
      stall_prev = out_valid && !out_ready;
      hold_d = out_data; hold_i = out_index; hold_l = out_last;
      if (abort_at >= 0 && exp_idx >= abort_at && ++stalls > 4) begin
        chk("full_no_issue", 64'({ram_rd_en, out_valid}), 64'({1'b0, 1'b1}));
        chk("full_occupancy", 64'(issued - exp_idx), 64'd2);
        return;
      end
    end
    start = 1'b0;
    chk("pass_done", 64'({done_seen, 7'(exp_idx)}), 64'({1'b1, 7'd64}));
    if (mode != 1) chk("full_rate", 64'(last_x - first_x), 64'd63);
    if (mode == 0) chk("last_beat_cycle", 64'(last_x), 64'd65);
  endtask

  task automatic fill(input int base, input int step);
    for (int i = 0; i < N; i++) mem[i] = DW'(base + i * step);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    fill(-32, 1);
    repeat (3) @(negedge clk);
    reset = 1'b0; #1;
    chk("reset_state", 64'({ram_rd_en, ram_addr, out_valid, out_data, out_index, out_last, busy, done}), 64'd0);

    // 1: ramp data, free-flowing sink
    run_pass(0, -1, -1);
`ifdef RESULT_READOUT_CHECKSUM_EN
    chk("csum_ramp", 64'(out_checksum), 64'(25'h1FFFFE0));
`endif
    @(negedge clk); #1;
    chk("done_pulse_end", 64'({done, busy}), 64'd0);

    // 2: toggling then stalled sink
    fill(-131000, 4099);
    run_pass(1, -1, -1);

    // 3: sign extremes
    fill(19'h3FFFF, 0);
    run_pass(0, -1, -1);
`ifdef RESULT_READOUT_CHECKSUM_EN
    chk("csum_maxpos", 64'(out_checksum), 64'(25'h0FFFFC0));
`endif
    fill(19'h40000, 0);
    run_pass(0, -1, -1);
    chk("min_neg_data", 64'(out_data), 64'(19'h40000));
`ifdef RESULT_READOUT_CHECKSUM_EN
    chk("csum_minneg", 64'(out_checksum), 64'(25'h1000000));
`endif

    // 4: start mid-pass ignored, then a fresh pass
    fill(-32, 1);
    run_pass(0, -1, 20);
`ifdef RESULT_READOUT_CHECKSUM_EN
    chk("csum_restart_ignored", 64'(out_checksum), 64'(25'h1FFFFE0));
`endif
    run_pass(0, -1, -1);

    // 5: reset with the buffer full
    run_pass(0, 30, -1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; #1;
    chk("mid_reset", 64'({ram_rd_en, ram_addr, out_valid, out_data, out_index, out_last, busy, done}), 64'd0);
`ifdef RESULT_READOUT_CHECKSUM_EN
    chk("mid_reset_csum", 64'(out_checksum), 64'd0);
`endif
    run_pass(0, -1, -1);

    // 6: sink held off for the first ten cycles
    run_pass(6, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
